// File: rtl/stall_controller_pkg.sv
// Shared pipeline-control definitions: stall FSM state codes, register-zero constant,
// and the forwarding-mux select encodings used by the EX-stage forwarding logic.
package stall_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN     = 2'd0;
    localparam state_t ST_STALL   = 2'd1;
    localparam state_t ST_MD_BUSY = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/stall_controller_hazard_match.sv
// Compares one producer destination against the ID-stage source registers.
// Purely combinational; r0 is never a producer because writes to it are discarded.
module hazard_match
    import stall_controller_pkg::*;
(
    input  logic [4:0] prod_a,
    input  logic [4:0] id_rs_a,
    input  logic [4:0] id_rt_a,
    input  logic       id_uses_rt,
    output logic       dep
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (prod_a == id_rs_a);
    assign rt_hit = id_uses_rt && (prod_a == id_rt_a);
    assign dep    = (prod_a != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/stall_controller.sv
// Holds IF/ID back when forwarding cannot cover a dependency, and freezes EX for mul/div.
// Outputs are combinational (same-cycle stall); optional perf counters under STALL_PERF_CNT_EN.
module stall_controller
    import stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_a,
    input  logic [4:0]       id_rt_a,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic [4:0]       ex_rd_a,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic [4:0]       mem_rd_a,
    input  logic             mem_MemRead,
    input  logic             ex_md_start,
    input  logic             md_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_hold,
    output logic             exmem_flush,
    output logic             md_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] md_cycles
`endif
);

    localparam int TW = $clog2(MD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(MD_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [1:0]    stall_cnt, stall_cnt_nxt;
    logic [TW-1:0] md_timer, md_timer_nxt;
    logic          timeout_set;
    logic          hazard_stall;
    logic          freeze;

    logic ex_dep;
    logic mem_dep;

    hazard_match u_ex_match (
        .prod_a     (ex_rd_a),
        .id_rs_a    (id_rs_a),
        .id_rt_a    (id_rt_a),
        .id_uses_rt (id_uses_rt),
        .dep        (ex_dep)
    );

    hazard_match u_mem_match (
        .prod_a     (mem_rd_a),
        .id_rs_a    (id_rs_a),
        .id_rt_a    (id_rt_a),
        .id_uses_rt (id_uses_rt),
        .dep        (mem_dep)
    );

    logic load_use;
    logic br_load;
    logic br_single;

    assign load_use  = ex_MemRead && ex_dep && !id_is_branch;
    assign br_load   = id_is_branch && ex_MemRead && ex_dep;
    assign br_single = id_is_branch &&
                       ((ex_RegWrite && !ex_MemRead && ex_dep) || (mem_MemRead && mem_dep));

    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        md_timer_nxt  = md_timer;
        timeout_set   = 1'b0;
        hazard_stall  = 1'b0;
        freeze        = 1'b0;
        ifid_flush    = 1'b0;

        // Reset overrides everything so the pipeline runs freely while rst is held.
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (ex_md_start) begin
                        freeze       = 1'b1;
                        state_nxt    = ST_MD_BUSY;
                        md_timer_nxt = '0;
                    end else if (load_use) begin
                        hazard_stall = 1'b1;
                    end else if (br_load) begin
                        // Load result reaches the ID comparator two cycles later.
                        hazard_stall  = 1'b1;
                        stall_cnt_nxt = 2'd1;
                        state_nxt     = ST_STALL;
                    end else if (br_single) begin
                        hazard_stall = 1'b1;
                    end else if (id_is_branch && id_branch_taken) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_STALL: begin
                    hazard_stall = 1'b1;
                    if (stall_cnt <= 2'd1) begin
                        stall_cnt_nxt = 2'd0;
                        state_nxt     = ST_RUN;
                    end else begin
                        stall_cnt_nxt = 2'(stall_cnt - 2'd1);
                    end
                end
                ST_MD_BUSY: begin
                    if (md_done) begin
                        state_nxt    = ST_RUN;
                        md_timer_nxt = '0;
                    end else begin
                        freeze = 1'b1;
                        if (md_timer == TMR_LAST) begin
                            timeout_set  = 1'b1;
                            state_nxt    = ST_RUN;
                            md_timer_nxt = '0;
                        end else begin
                            md_timer_nxt = TW'(md_timer + 1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign pc_write    = !(hazard_stall || freeze);
    assign ifid_write  = !(hazard_stall || freeze);
    assign idex_flush  = hazard_stall;
    assign ex_hold     = freeze;
    assign exmem_flush = freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            stall_cnt  <= 2'd0;
            md_timer   <= '0;
            md_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            md_timer  <= md_timer_nxt;
            if (timeout_set) begin
                md_timeout <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            md_cycles    <= '0;
        end else begin
            if (hazard_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if ((state == ST_MD_BUSY) && (md_cycles != '1)) begin
                md_cycles <= md_cycles + 1'b1;
            end
        end
    end
`endif

endmodule
